// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit.
// Operation encoding matches the MIPS funct-derived op field.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } mdu_state_t;

endpackage

// File: rtl/mdu_sign_fix.sv
// Sign correction of raw magnitude results from the multiply/divide core.
// Raw layout is {hi, lo}: product, or {remainder, quotient}.
module mdu_sign_fix
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] raw_i,
    input  mdu_op_t            op_i,
    input  logic               neg_res_i,
    input  logic               neg_rem_i,
    input  logic               dz_i,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o
);

    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   rem_neg;
    logic [WIDTH-1:0]   quo_neg;

    assign prod_neg = -raw_i;
    assign rem_neg  = -raw_i[2*WIDTH-1:WIDTH];
    assign quo_neg  = -raw_i[WIDTH-1:0];

    always_comb begin
        hi_o = raw_i[2*WIDTH-1:WIDTH];
        lo_o = raw_i[WIDTH-1:0];
        unique case (op_i)
            OP_MULT: begin
                if (neg_res_i) {hi_o, lo_o} = prod_neg;
            end
            OP_DIV: begin
                // Divide-by-zero keeps the all-ones quotient; remainder still
                // takes the dividend sign, which reproduces the original a.
                if (neg_res_i && !dz_i) lo_o = quo_neg;
                if (neg_rem_i) hi_o = rem_neg;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider owning HI and LO.
// One iteration per cycle for WIDTH cycles; a one-cycle DONE state follows.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    mdu_state_t         state_q, state_d;
    mdu_op_t            op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mb_q, mb_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_pend_q, dz_pend_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [WIDTH:0]     div_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;
    logic [2*WIDTH-1:0] div_nxt;
    logic [2*WIDTH-1:0] iter_nxt;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    // Signed ops have op[0] clear.
    assign a_neg = ~op[0] & a[WIDTH-1];
    assign b_neg = ~op[0] & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    assign addend  = p_q[0] ? mb_q : '0;
    assign mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    assign mul_nxt = {mul_sum, p_q[WIDTH-1:1]};

    // {remainder, dividend/quotient} shifts left one bit per iteration.
    assign div_sh  = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    assign div_ge  = div_sh >= {1'b0, mb_q};
    assign div_sub = div_sh[WIDTH-1:0] - mb_q;
    assign div_nxt = div_ge ? {div_sub, p_q[WIDTH-2:0], 1'b1}
                            : {div_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};

    assign iter_nxt = op_q[1] ? div_nxt : mul_nxt;

    mdu_sign_fix #(
        .WIDTH(WIDTH)
    ) u_sign_fix (
        .raw_i    (iter_nxt),
        .op_i     (op_q),
        .neg_res_i(neg_res_q),
        .neg_rem_i(neg_rem_q),
        .dz_i     (dz_pend_q),
        .hi_o     (fix_hi),
        .lo_o     (fix_lo)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        mb_d       = mb_q;
        p_d        = p_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        dz_pend_d  = dz_pend_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    op_d       = mdu_op_t'(op);
                    cnt_d      = '0;
                    mb_d       = b_mag;
                    p_d        = {{WIDTH{1'b0}}, a_mag};
                    neg_res_d  = a_neg ^ b_neg;
                    neg_rem_d  = a_neg & op[1];
                    dz_pend_d  = op[1] & (b == '0);
                    div_zero_d = 1'b0;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            S_RUN: begin
                p_d   = iter_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d    = S_DONE;
                    hi_d       = fix_hi;
                    lo_d       = fix_lo;
                    div_zero_d = dz_pend_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= OP_MULT;
            cnt_q      <= '0;
            mb_q       <= '0;
            p_q        <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_pend_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            mb_q       <= mb_d;
            p_q        <= p_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            dz_pend_q  <= dz_pend_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: 32-bit and 8-bit instances.
// Directed vectors push expected HI/LO/div_zero/done-cycle; monitors pop on done.
module tb_mult_div_unit;

    localparam logic [1:0] MULT  = 2'b00;
    localparam logic [1:0] MULTU = 2'b01;
    localparam logic [1:0] DIV   = 2'b10;
    localparam logic [1:0] DIVU  = 2'b11;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start32, hi_we, lo_we;
    logic [1:0]  op32;
    logic [31:0] a32, b32, wdata;
    logic        busy32, done32, dz32;
    logic [31:0] hi32, lo32;

    logic        start8;
    logic        hwe8 = 1'b0;
    logic        lwe8 = 1'b0;
    logic [1:0]  op8;
    logic [7:0]  a8, b8;
    logic [7:0]  wd8 = 8'h00;
    logic        busy8, done8, dz8;
    logic [7:0]  hi8, lo8;

    exp_t q32[$];
    exp_t q8[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_tot = 0;
    int   brun32 = 0;
    int   brun8 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mult_div_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .op(op32),
        .a(a32), .b(b32), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
    );

    mult_div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8),
        .a(a8), .b(b8), .hi_we(hwe8), .lo_we(lwe8), .wdata(wd8),
        .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (busy32) brun32++;
        if (done32) begin
            if (q32.size() == 0) begin
                check("unexpected_done32", 32'd0, 32'd1);
            end else begin
                e = q32.pop_front();
                check("hi32", hi32, e.hi);
                check("lo32", lo32, e.lo);
                check("dz32", {31'd0, dz32}, {31'd0, e.dz});
                check("done_cycle32", cyc, e.cyc);
                check("busy_cycles32", brun32, 32);
            end
        end
        if (!busy32) brun32 = 0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (busy8) brun8++;
        if (done8) begin
            if (q8.size() == 0) begin
                check("unexpected_done8", 32'd0, 32'd1);
            end else begin
                e = q8.pop_front();
                check("hi8", {24'd0, hi8}, e.hi);
                check("lo8", {24'd0, lo8}, e.lo);
                check("dz8", {31'd0, dz8}, {31'd0, e.dz});
                check("done_cycle8", cyc, e.cyc);
                check("busy_cycles8", brun8, 8);
            end
        end
        if (!busy8) brun8 = 0;
    end

    task automatic launch(input bit w8, input logic [1:0] o,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] eh, input logic [31:0] el,
                          input logic edz, input bit push);
        exp_t e;
        e.hi  = eh;
        e.lo  = el;
        e.dz  = edz;
        e.cyc = cyc + (w8 ? 9 : 33);
        if (w8) begin
            start8 = 1'b1; op8 = o; a8 = av[7:0]; b8 = bv[7:0];
            if (push) q8.push_back(e);
        end else begin
            start32 = 1'b1; op32 = o; a32 = av; b32 = bv;
            if (push) q32.push_back(e);
        end
        @(negedge clk);
        start32 = 1'b0;
        start8  = 1'b0;
    endtask

    task automatic wait_done(input bit w8, input string nm);
        int k = 0;
        while (!(w8 ? done8 : done32) && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!(w8 ? done8 : done32)) check({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic op_full(input bit w8, input logic [1:0] o,
                           input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] eh, input logic [31:0] el,
                           input logic edz, input string nm);
        launch(w8, o, av, bv, eh, el, edz, 1'b1);
        wait_done(w8, nm);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start32 = 1'b0; op32 = 2'b00; a32 = '0; b32 = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        check("rst_hi", hi32, 32'h0);
        check("rst_lo", lo32, 32'h0);
        check("rst_busy", {31'd0, busy32}, 32'd0);
        check("rst_done", {31'd0, done32}, 32'd0);
        check("rst_dz", {31'd0, dz32}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        launch(0, MULT, 32'hFFFF_FFFD, 32'd7,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b1);
        check("busy_cycle1", {31'd0, busy32}, 32'd1);
        wait_done(0, "mult_neg");
        @(negedge clk);
        check("idle_after_done", {30'd0, busy32, done32}, 32'd0);

        op_full(0, MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");
        op_full(0, DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "divu");
        op_full(0, DIV, 32'hFFFF_FFF9, 32'd2,
                32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg");
        op_full(0, DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                32'h0, 32'h8000_0000, 1'b0, "div_ovf");
        op_full(0, DIV, 32'hFFFF_FFFB, 32'd0,
                32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, "div_zero_neg");
        op_full(0, DIVU, 32'd5, 32'd0,
                32'd5, 32'hFFFF_FFFF, 1'b1, "divu_zero");
        check("dz_sticky", {31'd0, dz32}, 32'd1);

        launch(0, MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1'b1);
        check("dz_cleared", {31'd0, dz32}, 32'd0);
        wait_done(0, "multu_small");
        @(negedge clk);

        hi_we = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi", hi32, 32'h0000_1234);
        check("mthi_lo_kept", lo32, 32'd6);

        lo_we = 1'b1; wdata = 32'h0000_DEAD;
        launch(0, MULT, 32'd2, 32'd2, 32'd0, 32'd4, 1'b0, 1'b1);
        lo_we = 1'b0;
        check("lo_we_dropped", lo32, 32'd6);
        repeat (9) @(negedge clk);
        start32 = 1'b1; op32 = DIVU; a32 = 32'd100; b32 = 32'd7;
        hi_we = 1'b1; wdata = 32'h0000_5555;
        @(negedge clk);
        start32 = 1'b0; hi_we = 1'b0;
        check("hi_we_busy_ignored", hi32, 32'h0000_1234);
        wait_done(0, "mult_small");

        lo_we = 1'b1; wdata = 32'h0000_ABCD;
        start32 = 1'b1; op32 = MULT; a32 = 32'd3; b32 = 32'd3;
        @(negedge clk);
        lo_we = 1'b0; start32 = 1'b0;
        check("mtlo_in_done", lo32, 32'h0000_ABCD);
        check("hi_kept_done", hi32, 32'h0);
        check("start_in_done_ignored", {31'd0, busy32}, 32'd0);
        @(negedge clk);

        launch(0, DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy32}, 32'd0);
        check("abort_done", {31'd0, done32}, 32'd0);
        check("abort_hi", hi32, 32'h0);
        check("abort_lo", lo32, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op_full(0, DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, "divu_after_rst");

        op_full(1, MULT, 32'h80, 32'h80, 32'h40, 32'h00, 1'b0, "mult8");
        op_full(1, DIV, 32'h80, 32'hFF, 32'h00, 32'h80, 1'b0, "div8_ovf");
        op_full(1, MULTU, 32'hFF, 32'hFF, 32'hFE, 32'h01, 1'b0, "multu8");

        repeat (3) @(negedge clk);
        check("q32_drained", q32.size(), 32'd0);
        check("q8_drained", q8.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised, iterative multiply/divide unit for the MIPS datapath.
- Replaces the single-cycle MULT/DIV paths of the combinational ALU with a WIDTH-cycle shift-add multiplier and a restoring divider.
- Owns the architectural HI/LO registers, supports MTHI/MTLO writes, and reports busy/done so the control FSM can stall MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width; also the HI and LO width. Must be ≥4 and even.
- CNT_W, $clog2(WIDTH)+1, iteration counter width. Derived; not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a new operation; sampled only in IDLE
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  WIDTH  multiplicand / dividend (rs)
- b  in  WIDTH  multiplier / divisor (rt)
- hi_we  in  1  MTHI write strobe
- lo_we  in  1  MTLO write strobe
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when the HI/LO result is valid
- div_zero  out  1  sticky flag: last DIV/DIVU had b==0. Cleared on the next start.
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; hi=0, lo=0, busy=0, done=0, div_zero=0; counter and internal accumulators cleared. This applies at any point, including mid-operation; a partial result is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN: on an edge with start=1. Latch op, |a|, |b| (magnitudes for the signed ops), the result signs, and count=0. Assert div_zero_next = (op[1] && b==0).
  - RUN: one iteration per cycle; count increments. After iteration WIDTH-1, go RUN→DONE.
  - On that same edge, sign-corrected results are written into hi/lo.
  - DONE→IDLE: unconditional after one cycle.
- Latency:
  - The start cycle is cycle 0. busy=1 in cycles 1..WIDTH.
  - done=1 and the new hi/lo are visible in cycle WIDTH+1. busy=0 in DONE.
  - A new start is accepted no earlier than cycle WIDTH+2.
- Multiply (shift-add on magnitudes): {hi,lo} = 2*WIDTH-bit product.
  - MULT: product negated if sign(a)≠sign(b).
  - MULTU: no sign handling.
- Divide (restoring, on magnitudes): lo = quotient, hi = remainder.
  - DIV: quotient negated if signs differ; remainder takes the sign of the dividend (truncate toward zero).
  - Most-negative / -1: lo=most-negative, hi=0. No trap.
- Divide by zero: the operation still runs WIDTH cycles; div_zero=1 from DONE onward.
  - DIVU: hi=a, lo=all ones.
  - DIV: hi=a, lo=all ones. No sign correction is applied.
- start while busy or in DONE: ignored. No queueing.
- hi_we/lo_we:
  - Honoured only in IDLE or DONE; hi/lo update on the next edge.
  - Ignored while busy.
  - In the same IDLE cycle as start: start wins and the write is dropped.
  - In DONE: the write overrides the just-produced result for that register.
- a, b, op are don't-care outside the start cycle.

Decomposition:
- Package mdu_pkg holds:
  - typedef enum logic[1:0] mdu_op_t (MULT, MULTU, DIV, DIVU)
  - typedef enum logic[1:0] mdu_state_t (IDLE, RUN, DONE)
- One sub-module is natural: mdu_sign_fix (combinational).
  - Inputs: raw product or quotient/remainder, sign flags, op.
  - Outputs: corrected {hi,lo}.
  - Shared between the multiply and divide results.
- The FSM, counter and datapath registers stay in mult_div_unit.

Test Plan:
- MULT, WIDTH=32, a=0xFFFFFFFD (-3), b=7 → busy cycles 1..32; done in cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU, a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Also DIVU a=100, b=7 → lo=0x0000000E, hi=0x00000002.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=5, b=0 → hi=5, lo=0xFFFFFFFF, div_zero=1. The next start of MULTU 2*3 clears div_zero and yields hi=0, lo=6.
- MTHI 0x1234 in IDLE → hi=0x1234 next cycle. Then start MULT 2*2 with lo_we=1 in the same cycle → lo_we dropped, lo=4 at done. A second start plus hi_we in cycle 10 → both ignored, hi=0 at done.
- Assert rst_n=0 in cycle 15 of a DIV → immediately state=IDLE, busy=0, hi=lo=0, no done pulse. Release rst_n, then DIVU 9/3 → lo=3, hi=0 in cycle 33.
- WIDTH=8 run: MULT a=0x80, b=0x80 → hi=0x40, lo=0x00; done in cycle 9.
